// File: rtl/ctrl_pkg.sv
// Shared constants and types for the control decode stage.
package ctrl_pkg;

    // Base RV32 major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // ALU function codes
    localparam logic [3:0] ALU_ADD      = 4'd0;
    localparam logic [3:0] ALU_SUB      = 4'd1;
    localparam logic [3:0] ALU_SLL      = 4'd2;
    localparam logic [3:0] ALU_SLT      = 4'd3;
    localparam logic [3:0] ALU_SLTU     = 4'd4;
    localparam logic [3:0] ALU_XOR      = 4'd5;
    localparam logic [3:0] ALU_SRL      = 4'd6;
    localparam logic [3:0] ALU_SRA      = 4'd7;
    localparam logic [3:0] ALU_OR       = 4'd8;
    localparam logic [3:0] ALU_AND      = 4'd9;
    localparam logic [3:0] ALU_ADD_JALR = 4'd10;

    // Writeback source select
    localparam logic [1:0] RD_ALU  = 2'd0;
    localparam logic [1:0] RD_LUI  = 2'd1;
    localparam logic [1:0] RD_LINK = 2'd2;
    localparam logic [1:0] RD_LOAD = 2'd3;

    // Memory access size / sign-extension codes
    localparam logic [2:0] SX_B  = 3'd0;
    localparam logic [2:0] SX_BU = 3'd1;
    localparam logic [2:0] SX_H  = 3'd2;
    localparam logic [2:0] SX_HU = 3'd3;
    localparam logic [2:0] SX_W  = 3'd4;

    // Crypto operation codes
    localparam logic [3:0] CR_NONE        = 4'd0;
    localparam logic [3:0] CR_SHA256_SUM0 = 4'd1;
    localparam logic [3:0] CR_SHA256_SUM1 = 4'd2;
    localparam logic [3:0] CR_SHA256_SIG0 = 4'd3;
    localparam logic [3:0] CR_SHA256_SIG1 = 4'd4;
    localparam logic [3:0] CR_AES32_ESI   = 4'd5;
    localparam logic [3:0] CR_AES32_ESMI  = 4'd6;
    localparam logic [3:0] CR_AES32_DSI   = 4'd7;
    localparam logic [3:0] CR_AES32_DSMI  = 4'd8;
    localparam logic [3:0] CR_SM4_ED      = 4'd9;
    localparam logic [3:0] CR_SM4_KS      = 4'd10;

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_LOAD_BUBBLE = 2'd1,
        ST_CRYPTO_BUSY = 2'd2
    } stage_state_e;

    // Control bundle without the XLEN-wide immediate
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] alu_func;
        logic       mux_a_sel;
        logic       mux_b_sel;
        logic       pc_add_sel;
        logic       pc_next_sel;
        logic       jal_sel;
        logic       reg_we;
        logic       mem_we;
        logic       load_o;
        logic [1:0] rd_sel;
        logic [2:0] sx_size;
        logic [3:0] crypto_op;
        logic [1:0] bs;
        logic       illegal;
    } ctrl_bundle_t;

    // Opcodes whose rs2 field is a real source register
    function automatic logic is_rsb(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

    // AES32/SM4 op from instruction[29:25]; CR_NONE when not a crypto pattern
    function automatic logic [3:0] aes_sm4_op(input logic [4:0] f5);
        case (f5)
            5'b10001: return CR_AES32_ESI;
            5'b10011: return CR_AES32_ESMI;
            5'b10101: return CR_AES32_DSI;
            5'b10111: return CR_AES32_DSMI;
            5'b11000: return CR_SM4_ED;
            5'b11010: return CR_SM4_KS;
            default:  return CR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// Handshake and control-bundle signals between fetch, decode stage and execute.
interface ctrl_decode_stage_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_val;
    logic [3:0]      alu_func;
    logic            mux_a_sel;
    logic            mux_b_sel;
    logic            pc_add_sel;
    logic            pc_next_sel;
    logic            jal_sel;
    logic            reg_we;
    logic            mem_we;
    logic            load_o;
    logic [1:0]      rd_sel;
    logic [2:0]      sx_size;
    logic [3:0]      crypto_op;
    logic [1:0]      bs;
    logic            illegal;

    // Decode stage side
    modport slave (
        input  in_valid, instruction, flush, out_ready,
        output in_ready, out_valid, rs1, rs2, rd, imm_val, alu_func,
               mux_a_sel, mux_b_sel, pc_add_sel, pc_next_sel, jal_sel,
               reg_we, mem_we, load_o, rd_sel, sx_size, crypto_op, bs, illegal
    );

    // Surrounding pipeline side
    modport master (
        output in_valid, instruction, flush, out_ready,
        input  in_ready, out_valid, rs1, rs2, rd, imm_val, alu_func,
               mux_a_sel, mux_b_sel, pc_add_sel, pc_next_sel, jal_sel,
               reg_we, mem_we, load_o, rd_sel, sx_size, crypto_op, bs, illegal
    );
endinterface

// File: rtl/insn_decode.sv
// Purely combinational RV32 + Zknh/Zkne/Zksed instruction to control bundle mapping.
module insn_decode
    import ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit EN_ZKNE = 1'b1,
    parameter bit EN_ZKNH = 1'b1
) (
    input  logic [31:0]     i_insn,
    output ctrl_bundle_t    o_ctrl,
    output logic [XLEN-1:0] o_imm
);

    logic [6:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic [6:0]   w_funct7;
    logic [31:0]  w_imm_i;
    logic [31:0]  w_imm_s;
    logic [31:0]  w_imm_b;
    logic [31:0]  w_imm_u;
    logic [31:0]  w_imm_j;
    logic [31:0]  w_imm32;
    logic [3:0]   w_aes_op;
    logic         w_legal;
    ctrl_bundle_t w_ctrl;

    assign w_opcode = i_insn[6:0];
    assign w_funct3 = i_insn[14:12];
    assign w_funct7 = i_insn[31:25];
    assign w_aes_op = aes_sm4_op(i_insn[29:25]);

    assign w_imm_i = {{20{i_insn[31]}}, i_insn[31:20]};
    assign w_imm_s = {{20{i_insn[31]}}, i_insn[31:25], i_insn[11:7]};
    assign w_imm_b = {{19{i_insn[31]}}, i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0};
    assign w_imm_u = {i_insn[31:12], 12'b0};
    assign w_imm_j = {{11{i_insn[31]}}, i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0};

    // Opcode/funct decode; illegal encodings are scrubbed of all side effects at the end
    always_comb begin
        w_ctrl      = '0;
        w_imm32     = '0;
        w_legal     = 1'b0;
        w_ctrl.rs1  = i_insn[19:15];
        w_ctrl.rs2  = i_insn[24:20];
        w_ctrl.rd   = i_insn[11:7];
        w_ctrl.bs   = i_insn[31:30];
        case (w_opcode)
            OPC_LUI: begin
                w_legal          = 1'b1;
                w_ctrl.reg_we    = 1'b1;
                w_ctrl.mux_b_sel = 1'b1;
                w_ctrl.rd_sel    = RD_LUI;
                w_imm32          = w_imm_u;
            end
            OPC_AUIPC: begin
                w_legal          = 1'b1;
                w_ctrl.reg_we    = 1'b1;
                w_ctrl.mux_a_sel = 1'b1;
                w_ctrl.mux_b_sel = 1'b1;
                w_ctrl.alu_func  = ALU_ADD;
                w_ctrl.rd_sel    = RD_ALU;
                w_imm32          = w_imm_u;
            end
            OPC_JAL: begin
                w_legal           = 1'b1;
                w_ctrl.reg_we     = 1'b1;
                w_ctrl.mux_a_sel  = 1'b1;
                w_ctrl.mux_b_sel  = 1'b1;
                w_ctrl.pc_add_sel = 1'b1;
                w_ctrl.jal_sel    = 1'b1;
                w_ctrl.rd_sel     = RD_LINK;
                w_imm32           = w_imm_j;
            end
            OPC_JALR: begin
                w_legal            = (w_funct3 == 3'b000);
                w_ctrl.reg_we      = 1'b1;
                w_ctrl.mux_b_sel   = 1'b1;
                w_ctrl.pc_next_sel = 1'b1;
                w_ctrl.jal_sel     = 1'b1;
                w_ctrl.alu_func    = ALU_ADD_JALR;
                w_ctrl.rd_sel      = RD_LINK;
                w_imm32            = w_imm_i;
            end
            OPC_BRANCH: begin
                // Comparison is resolved downstream; the ALU code says which compare
                w_legal = 1'b1;
                w_imm32 = w_imm_b;
                case (w_funct3)
                    3'b000, 3'b001: w_ctrl.alu_func = ALU_SUB;
                    3'b100, 3'b101: w_ctrl.alu_func = ALU_SLT;
                    3'b110, 3'b111: w_ctrl.alu_func = ALU_SLTU;
                    default:        w_legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                w_legal          = 1'b1;
                w_ctrl.reg_we    = 1'b1;
                w_ctrl.load_o    = 1'b1;
                w_ctrl.mux_b_sel = 1'b1;
                w_ctrl.rd_sel    = RD_LOAD;
                w_imm32          = w_imm_i;
                case (w_funct3)
                    3'b000:  w_ctrl.sx_size = SX_B;
                    3'b001:  w_ctrl.sx_size = SX_H;
                    3'b010:  w_ctrl.sx_size = SX_W;
                    3'b100:  w_ctrl.sx_size = SX_BU;
                    3'b101:  w_ctrl.sx_size = SX_HU;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                w_legal          = 1'b1;
                w_ctrl.mem_we    = 1'b1;
                w_ctrl.mux_b_sel = 1'b1;
                w_imm32          = w_imm_s;
                case (w_funct3)
                    3'b000:  w_ctrl.sx_size = SX_B;
                    3'b001:  w_ctrl.sx_size = SX_H;
                    3'b010:  w_ctrl.sx_size = SX_W;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                w_legal          = 1'b1;
                w_ctrl.reg_we    = 1'b1;
                w_ctrl.mux_b_sel = 1'b1;
                w_imm32          = w_imm_i;
                case (w_funct3)
                    3'b000: w_ctrl.alu_func = ALU_ADD;
                    3'b010: w_ctrl.alu_func = ALU_SLT;
                    3'b011: w_ctrl.alu_func = ALU_SLTU;
                    3'b100: w_ctrl.alu_func = ALU_XOR;
                    3'b110: w_ctrl.alu_func = ALU_OR;
                    3'b111: w_ctrl.alu_func = ALU_AND;
                    3'b001: begin
                        if (w_funct7 == 7'b0000000) begin
                            w_ctrl.alu_func = ALU_SLL;
                        end else if (EN_ZKNH && w_funct7 == 7'b0001000 && i_insn[24:22] == 3'b000) begin
                            // SHA256 unary ops share the SLLI slot; rs2 field selects the op
                            w_ctrl.mux_b_sel = 1'b0;
                            case (i_insn[21:20])
                                2'd0: w_ctrl.crypto_op = CR_SHA256_SUM0;
                                2'd1: w_ctrl.crypto_op = CR_SHA256_SUM1;
                                2'd2: w_ctrl.crypto_op = CR_SHA256_SIG0;
                                2'd3: w_ctrl.crypto_op = CR_SHA256_SIG1;
                            endcase
                        end else begin
                            w_legal = 1'b0;
                        end
                    end
                    3'b101: begin
                        if (w_funct7 == 7'b0000000) begin
                            w_ctrl.alu_func = ALU_SRL;
                        end else if (w_funct7 == 7'b0100000) begin
                            w_ctrl.alu_func = ALU_SRA;
                        end else begin
                            w_legal = 1'b0;
                        end
                    end
                endcase
            end
            OPC_OP: begin
                w_legal       = 1'b1;
                w_ctrl.reg_we = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    case (w_funct3)
                        3'b000: w_ctrl.alu_func = ALU_ADD;
                        3'b001: w_ctrl.alu_func = ALU_SLL;
                        3'b010: w_ctrl.alu_func = ALU_SLT;
                        3'b011: w_ctrl.alu_func = ALU_SLTU;
                        3'b100: w_ctrl.alu_func = ALU_XOR;
                        3'b101: w_ctrl.alu_func = ALU_SRL;
                        3'b110: w_ctrl.alu_func = ALU_OR;
                        3'b111: w_ctrl.alu_func = ALU_AND;
                    endcase
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
                    w_ctrl.alu_func = ALU_SUB;
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) begin
                    w_ctrl.alu_func = ALU_SRA;
                end else if (EN_ZKNE && w_funct3 == 3'b000 && w_aes_op != CR_NONE) begin
                    // bs in [31:30] rides along in the bundle for the crypto unit
                    w_ctrl.crypto_op = w_aes_op;
                end else begin
                    w_legal = 1'b0;
                end
            end
            OPC_SYSTEM, OPC_FENCE: begin
                w_legal = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase

        if (w_ctrl.crypto_op != CR_NONE) begin
            w_ctrl.reg_we = (w_ctrl.rd != 5'd0);
        end

        if (!w_legal) begin
            w_ctrl.reg_we    = 1'b0;
            w_ctrl.mem_we    = 1'b0;
            w_ctrl.load_o    = 1'b0;
            w_ctrl.crypto_op = CR_NONE;
        end
        w_ctrl.illegal = !w_legal;
    end

    assign o_ctrl = w_ctrl;
    assign o_imm  = XLEN'($signed(w_imm32));

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage: valid/ready handshake, load-use bubble and crypto occupancy.
//
//   state          | meaning
//   ---------------+---------------------------------------------------------
//   ST_RUN         | normal flow, in_ready follows handshake and hazard check
//   ST_LOAD_BUBBLE | one dead cycle after a load left with a dependent behind it
//   ST_CRYPTO_BUSY | crypto unit occupied, counting down r_cnt
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CRYPTO_LAT = 2,
    parameter bit EN_ZKNE    = 1'b1,
    parameter bit EN_ZKNH    = 1'b1
) (
    input logic                clk,
    input logic                rst,
    ctrl_decode_stage_if.slave bus
);

    localparam int CNT_W = 4;

    ctrl_bundle_t    w_ctrl;
    logic [XLEN-1:0] w_imm;
    logic [4:0]      w_in_rs1;
    logic [4:0]      w_in_rs2;
    logic [6:0]      w_in_opc;
    logic            w_hazard;
    logic            w_in_ready;
    logic            w_take_in;
    logic            w_take_out;

    ctrl_bundle_t    r_ctrl;
    logic [XLEN-1:0] r_imm;
    logic            r_out_valid;
    stage_state_e    r_state;
    logic [CNT_W-1:0] r_cnt;

    insn_decode #(
        .XLEN    (XLEN),
        .EN_ZKNE (EN_ZKNE),
        .EN_ZKNH (EN_ZKNH)
    ) u_insn_decode (
        .i_insn (bus.instruction),
        .o_ctrl (w_ctrl),
        .o_imm  (w_imm)
    );

    assign w_in_rs1 = bus.instruction[19:15];
    assign w_in_rs2 = bus.instruction[24:20];
    assign w_in_opc = bus.instruction[6:0];

    // Load-use hazard against the bundle currently held in the output register
    assign w_hazard = r_out_valid && r_ctrl.load_o && (r_ctrl.rd != 5'd0) &&
                      ((w_in_rs1 == r_ctrl.rd) || (is_rsb(w_in_opc) && (w_in_rs2 == r_ctrl.rd)));

    // rst gates in_ready so nothing looks acceptable while reset is held
    assign w_in_ready = rst && (r_state == ST_RUN) && !bus.flush &&
                        (!r_out_valid || bus.out_ready) && !w_hazard;
    assign w_take_in  = bus.in_valid && w_in_ready;
    assign w_take_out = r_out_valid && bus.out_ready;

    // Stage FSM and crypto occupancy down-counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else if (bus.flush) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_take_out && r_ctrl.load_o && w_hazard) begin
                        r_state <= ST_LOAD_BUBBLE;
                    end else if (w_take_out && (r_ctrl.crypto_op != CR_NONE) && (CRYPTO_LAT > 1)) begin
                        r_state <= ST_CRYPTO_BUSY;
                        r_cnt   <= CNT_W'(CRYPTO_LAT - 1);
                    end
                end
                ST_LOAD_BUBBLE: begin
                    r_state <= ST_RUN;
                end
                ST_CRYPTO_BUSY: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Output bundle register; holds whenever nothing new is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_ctrl      <= '0;
            r_imm       <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_take_in) begin
            r_out_valid <= 1'b1;
            r_ctrl      <= w_ctrl;
            r_imm       <= w_imm;
        end else if (w_take_out) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.rs1         = r_ctrl.rs1;
    assign bus.rs2         = r_ctrl.rs2;
    assign bus.rd          = r_ctrl.rd;
    assign bus.imm_val     = r_imm;
    assign bus.alu_func    = r_ctrl.alu_func;
    assign bus.mux_a_sel   = r_ctrl.mux_a_sel;
    assign bus.mux_b_sel   = r_ctrl.mux_b_sel;
    assign bus.pc_add_sel  = r_ctrl.pc_add_sel;
    assign bus.pc_next_sel = r_ctrl.pc_next_sel;
    assign bus.jal_sel     = r_ctrl.jal_sel;
    assign bus.reg_we      = r_ctrl.reg_we;
    assign bus.mem_we      = r_ctrl.mem_we;
    assign bus.load_o      = r_ctrl.load_o;
    assign bus.rd_sel      = r_ctrl.rd_sel;
    assign bus.sx_size     = r_ctrl.sx_size;
    assign bus.crypto_op   = r_ctrl.crypto_op;
    assign bus.bs          = r_ctrl.bs;
    assign bus.illegal     = r_ctrl.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: one instance with full crypto and CRYPTO_LAT=3,
// one with XLEN=64, CRYPTO_LAT=1 and AES/SM4 disabled.
module tb_ctrl_decode_stage;

    localparam logic [31:0] I_ADDI5   = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_LW      = 32'h0000A103;  // lw   x2,0(x1)
    localparam logic [31:0] I_ADD     = 32'h002101B3;  // add  x3,x2,x2
    localparam logic [31:0] I_SHA     = 32'h10231293;  // sha256sig0 x5,x6
    localparam logic [31:0] I_ADDIM1  = 32'hFFF00213;  // addi x4,x0,-1
    localparam logic [31:0] I_SW      = 32'h00312423;  // sw   x3,8(x2)
    localparam logic [31:0] I_AES     = 32'h629403B3;  // aes32esi x7,x8,x9,bs=1
    localparam logic [31:0] I_LUI     = 32'h800002B7;  // lui  x5,0x80000
    localparam logic [31:0] I_BADOPC  = 32'hFFFFFFFF;  // unknown opcode

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ctrl_decode_stage_if #(.XLEN(32)) bus_a ();
    ctrl_decode_stage_if #(.XLEN(64)) bus_b ();

    ctrl_decode_stage #(
        .XLEN       (32),
        .CRYPTO_LAT (3),
        .EN_ZKNE    (1'b1),
        .EN_ZKNH    (1'b1)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    ctrl_decode_stage #(
        .XLEN       (64),
        .CRYPTO_LAT (1),
        .EN_ZKNE    (1'b0),
        .EN_ZKNH    (1'b1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.in_valid    = 1'b1;
        bus_a.instruction = I_ADDI5;
        bus_a.flush       = 1'b0;
        bus_a.out_ready   = 1'b1;
        bus_b.in_valid    = 1'b0;
        bus_b.instruction = 32'h0;
        bus_b.flush       = 1'b0;
        bus_b.out_ready   = 1'b0;

        // reset state, with a request already pending on the input
        cyc();
        cyc();
        check("rst_out_valid", bus_a.out_valid, 0);
        check("rst_in_ready", bus_a.in_ready, 0);
        check("rst_imm", bus_a.imm_val, 0);
        check("rst_rd", bus_a.rd, 0);
        check("rst_reg_we", bus_a.reg_we, 0);
        check("rst_illegal", bus_a.illegal, 0);
        check("rst_b_out_valid", bus_b.out_valid, 0);
        rst = 1'b1;
        #1;

        // addi x1,x0,5
        check("addi_in_ready", bus_a.in_ready, 1);
        cyc();
        bus_a.in_valid = 1'b0;
        #1;
        check("addi_out_valid", bus_a.out_valid, 1);
        check("addi_alu", bus_a.alu_func, 0);
        check("addi_imm", bus_a.imm_val, 5);
        check("addi_reg_we", bus_a.reg_we, 1);
        check("addi_rd", bus_a.rd, 1);
        check("addi_mux_b", bus_a.mux_b_sel, 1);
        check("addi_illegal", bus_a.illegal, 0);
        cyc();
        check("addi_drained", bus_a.out_valid, 0);

        // lw x2 then dependent add x3,x2,x2
        bus_a.in_valid    = 1'b1;
        bus_a.instruction = I_LW;
        cyc();
        bus_a.instruction = I_ADD;
        #1;
        check("lw_out_valid", bus_a.out_valid, 1);
        check("lw_load_o", bus_a.load_o, 1);
        check("lw_sx_size", bus_a.sx_size, 4);
        check("lw_rd_sel", bus_a.rd_sel, 3);
        check("lw_rd", bus_a.rd, 2);
        check("lw_hazard_in_ready", bus_a.in_ready, 0);
        cyc();
        check("bubble_out_valid", bus_a.out_valid, 0);
        check("bubble_in_ready", bus_a.in_ready, 0);
        cyc();
        check("post_bubble_in_ready", bus_a.in_ready, 1);
        check("post_bubble_out_valid", bus_a.out_valid, 0);
        cyc();
        bus_a.instruction = I_SHA;
        #1;
        check("add_out_valid", bus_a.out_valid, 1);
        check("add_rd", bus_a.rd, 3);
        check("add_mux_b", bus_a.mux_b_sel, 0);
        check("add_load_o", bus_a.load_o, 0);
        check("add_in_ready", bus_a.in_ready, 1);

        // sha256sig0, CRYPTO_LAT=3
        cyc();
        bus_a.in_valid = 1'b0;
        #1;
        check("sha_out_valid", bus_a.out_valid, 1);
        check("sha_crypto_op", bus_a.crypto_op, 3);
        check("sha_rd", bus_a.rd, 5);
        check("sha_rs1", bus_a.rs1, 6);
        check("sha_reg_we", bus_a.reg_we, 1);
        check("sha_illegal", bus_a.illegal, 0);
        cyc();
        bus_a.in_valid    = 1'b1;
        bus_a.instruction = I_ADDIM1;
        #1;
        check("busy1_in_ready", bus_a.in_ready, 0);
        check("busy1_out_valid", bus_a.out_valid, 0);
        cyc();
        check("busy2_in_ready", bus_a.in_ready, 0);
        cyc();
        check("busy_done_in_ready", bus_a.in_ready, 1);
        cyc();

        // output stall: out_ready low for 4 cycles
        bus_a.instruction = I_SW;
        bus_a.out_ready   = 1'b0;
        #1;
        check("addim1_out_valid", bus_a.out_valid, 1);
        check("addim1_imm", bus_a.imm_val, 64'hFFFF_FFFF);
        check("addim1_rd", bus_a.rd, 4);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("stall_out_valid", bus_a.out_valid, 1);
            check("stall_imm", bus_a.imm_val, 64'hFFFF_FFFF);
            check("stall_rd", bus_a.rd, 4);
            check("stall_in_ready", bus_a.in_ready, 0);
        end
        bus_a.out_ready = 1'b1;
        #1;
        check("release_in_ready", bus_a.in_ready, 1);
        cyc();
        bus_a.in_valid = 1'b0;
        #1;
        check("sw_out_valid", bus_a.out_valid, 1);
        check("sw_mem_we", bus_a.mem_we, 1);
        check("sw_reg_we", bus_a.reg_we, 0);
        check("sw_imm", bus_a.imm_val, 8);
        check("sw_rs2", bus_a.rs2, 3);
        check("sw_sx_size", bus_a.sx_size, 4);
        cyc();

        // aes32esi then flush during CRYPTO_BUSY with a pending instruction
        bus_a.in_valid    = 1'b1;
        bus_a.instruction = I_AES;
        cyc();
        bus_a.in_valid = 1'b0;
        #1;
        check("aes_out_valid", bus_a.out_valid, 1);
        check("aes_crypto_op", bus_a.crypto_op, 5);
        check("aes_bs", bus_a.bs, 1);
        check("aes_rd", bus_a.rd, 7);
        check("aes_reg_we", bus_a.reg_we, 1);
        cyc();
        bus_a.flush       = 1'b1;
        bus_a.in_valid    = 1'b1;
        bus_a.instruction = I_ADDI5;
        #1;
        check("flush_in_ready", bus_a.in_ready, 0);
        cyc();
        bus_a.flush    = 1'b0;
        bus_a.in_valid = 1'b0;
        #1;
        check("flushed_out_valid", bus_a.out_valid, 0);
        check("flushed_run_in_ready", bus_a.in_ready, 1);
        check("flushed_rd_kept", bus_a.rd, 7);
        check("flushed_imm_kept", bus_a.imm_val, 0);
        cyc();

        // reset pulsed inside a load bubble
        bus_a.in_valid    = 1'b1;
        bus_a.instruction = I_LW;
        cyc();
        bus_a.instruction = I_ADD;
        #1;
        check("lw2_in_ready", bus_a.in_ready, 0);
        cyc();
        check("bubble2_in_ready", bus_a.in_ready, 0);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", bus_a.out_valid, 0);
        check("midrst_in_ready", bus_a.in_ready, 0);
        check("midrst_rd", bus_a.rd, 0);
        check("midrst_load_o", bus_a.load_o, 0);
        check("midrst_rd_sel", bus_a.rd_sel, 0);
        check("midrst_sx_size", bus_a.sx_size, 0);
        check("midrst_crypto_op", bus_a.crypto_op, 0);
        #2;
        rst = 1'b1;
        #1;
        check("after_rst_in_ready", bus_a.in_ready, 1);
        cyc();
        bus_a.in_valid = 1'b0;
        #1;
        check("after_rst_add_valid", bus_a.out_valid, 1);
        check("after_rst_add_rd", bus_a.rd, 3);
        cyc();

        // second instance: AES disabled, CRYPTO_LAT=1, XLEN=64
        bus_b.out_ready   = 1'b1;
        bus_b.in_valid    = 1'b1;
        bus_b.instruction = I_AES;
        cyc();
        bus_b.instruction = I_SHA;
        #1;
        check("b_aes_out_valid", bus_b.out_valid, 1);
        check("b_aes_illegal", bus_b.illegal, 1);
        check("b_aes_reg_we", bus_b.reg_we, 0);
        check("b_aes_crypto_op", bus_b.crypto_op, 0);
        cyc();
        bus_b.instruction = I_LUI;
        #1;
        check("b_sha_crypto_op", bus_b.crypto_op, 3);
        check("b_sha_illegal", bus_b.illegal, 0);
        check("b_sha_in_ready", bus_b.in_ready, 1);
        cyc();
        bus_b.instruction = I_BADOPC;
        #1;
        check("b_lat1_no_busy", bus_b.in_ready, 1);
        check("b_lui_out_valid", bus_b.out_valid, 1);
        check("b_lui_imm64", bus_b.imm_val, 64'hFFFF_FFFF_8000_0000);
        check("b_lui_rd_sel", bus_b.rd_sel, 1);
        check("b_lui_rd", bus_b.rd, 5);
        cyc();
        bus_b.in_valid = 1'b0;
        #1;
        check("b_bad_illegal", bus_b.illegal, 1);
        check("b_bad_reg_we", bus_b.reg_we, 0);
        check("b_bad_mem_we", bus_b.mem_we, 0);
        cyc();
        check("b_drained", bus_b.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_stage.md
CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, width of imm_val; legal values are 32 and 64.
REQ-002 Parameter CRYPTO_LAT, default 2, crypto unit occupancy in cycles; legal range is 1..8.
REQ-003 Parameter EN_ZKNE, default 1; when it is 0, AES32/SM4 encodings decode as illegal.
REQ-004 Parameter EN_ZKNH, default 1; when it is 0, SHA256 encodings decode as illegal.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  instruction present.
REQ-008 in_ready  out  1  stage accepts the instruction.
REQ-009 instruction  in  32  RV32 instruction word.
REQ-010 flush  in  1  synchronous pipeline kill.
REQ-011 out_valid  out  1  registered control bundle valid.
REQ-012 out_ready  in  1  downstream accepts the bundle.
REQ-013 rs1, rs2, rd  out  5 each  register indices.
REQ-014 imm_val  out  XLEN  sign-extended immediate.
REQ-015 alu_func  out  4  ALU function code (ADD=0 .. AND=9, ADD_JALR=10).
REQ-016 mux_a_sel, mux_b_sel, pc_add_sel, pc_next_sel, jal_sel, reg_we, mem_we, load_o  out  1 each  datapath controls.
REQ-017 rd_sel  out  2  writeback source: 0 ALU, 1 LUI, 2 link, 3 load.
REQ-018 sx_size  out  3  memory size code: 0 b, 1 bu, 2 h, 3 hu, 4 w.
REQ-019 crypto_op  out  4  0 none, 1-4 sha256 sum0/sum1/sig0/sig1, 5-8 aes32 esi/esmi/dsi/dsmi, 9 sm4ed, 10 sm4ks.
REQ-020 bs  out  2  byte select, taken from instruction[31:30].
REQ-021 illegal  out  1  the instruction is unsupported.

Function
REQ-022 Transfer into the stage occurs when in_valid & in_ready; transfer out occurs when out_valid & out_ready.
REQ-023 Decode latency is 1 cycle: the bundle is registered, and out_valid rises on the edge after the input transfer.
REQ-024 In state RUN, in_ready = !flush & (!out_valid | out_ready) & !hazard.
REQ-025 hazard = out_valid & load_o & rd!=0 & (incoming rs1==rd | (incoming opcode is R/S/B and incoming rs2==rd)).
REQ-026 The FSM states are RUN, LOAD_BUBBLE and CRYPTO_BUSY; in_ready is 0 in both LOAD_BUBBLE and CRYPTO_BUSY.
REQ-027 When a load transfers out while hazard is true, RUN goes to LOAD_BUBBLE for exactly 1 cycle, then returns to RUN.
REQ-028 When a bundle with crypto_op!=0 transfers out and CRYPTO_LAT>1, RUN goes to CRYPTO_BUSY with the counter loaded to CRYPTO_LAT-1.
REQ-029 In CRYPTO_BUSY the counter decrements each cycle; the FSM returns to RUN in the cycle after the counter reaches 1.
REQ-030 When CRYPTO_LAT=1, the CRYPTO_BUSY state is never entered.
REQ-031 While out_valid & !out_ready, all outputs hold stable.
REQ-032 flush clears out_valid, forces the FSM to RUN and clears the counter on the next edge, overriding any simultaneous transfer in.
REQ-033 Base decode covers LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM and FENCE.
REQ-034 Control encoding and branch evaluation follow the existing control_unit encoding; branches resolve downstream, so pc_add_sel is asserted only for JAL.
REQ-035 SHA256 decodes from: opcode 0010011, funct3 001, instruction[31:25]=0001000, instruction[24:20]=0..3.
REQ-036 AES32/SM4 decode from: opcode 0110011, funct3 000, instruction[29:25] in {10001, 10011, 10101, 10111, 11000, 11010}.
REQ-037 For every crypto op, reg_we = (rd!=0) and rd is taken from instruction[11:7].
REQ-038 An unknown opcode, an unsupported funct combination, or a disabled extension sets illegal=1 and forces reg_we=0, mem_we=0, crypto_op=0.
REQ-039 imm_val is sign-extended from instruction[31] to XLEN bits.

Reset
REQ-040 While rst=0: out_valid=0, in_ready=0, FSM=RUN, counter=0, and every bundle output register is 0.
REQ-041 Reset asserted mid-operation (LOAD_BUBBLE or CRYPTO_BUSY) aborts the operation immediately; no residual bubble remains after release.

Structure
REQ-042 Package ctrl_pkg holds: opcode constants, ALU function codes, sx_size codes, crypto_op codes and the FSM state enum.
REQ-043 A single combinational sub-module insn_decode maps the instruction to the unregistered bundle; ctrl_decode_stage adds the registers, FSM and handshake.

Verification
REQ-044 Scenario: addi x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, alu_func=0, imm_val=5, reg_we=1, rd=1.
REQ-045 Scenario: lw x2,0(x1) followed by add x3,x2,x2 -> the add is withheld for 1 extra cycle (LOAD_BUBBLE), then issues.
REQ-046 Scenario: sha256sig0 x5,x6 (0x10231293), CRYPTO_LAT=3 -> crypto_op=3; in_ready stays 0 for 2 cycles after its transfer out.
REQ-047 Scenario: out_ready=0 for 4 cycles with a valid bundle -> outputs stable and in_ready=0; on release, the next instruction is accepted the same cycle.
REQ-048 Scenario: flush asserted in CRYPTO_BUSY with in_valid=1 -> next cycle out_valid=0, FSM=RUN; the instruction is not captured.
REQ-049 Scenario: EN_ZKNE=0 with aes32esi -> illegal=1, reg_we=0; reset pulsed mid-bubble -> all outputs 0.
